// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// Optional break support is compiled in with UART_TX_BREAK_EN.
`ifndef FCLK
`define FCLK 50000000
`endif

package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
`ifdef UART_TX_BREAK_EN
    ,
    S_BRK,
    S_MARK
`endif
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int bit_period(input int bauds);
    return `FCLK / bauds;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; writes when full and
// reads when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             wr;
  logic             rd;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rp];

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      case ({wr, rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (wr) mem[wp] <= din;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// FIFO-buffered UART transmitter, frames sent back-to-back.
// Define UART_TX_BREAK_EN to add the BRK line-break input.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int BAUDS  = 115200,
  parameter int W      = 8,
  parameter int WSTOP  = 1,
  parameter int PARITY = 0,
  parameter int DEPTH  = 16,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          NRST,
  input  logic [W-1:0]  IN,
  input  logic          OE,
  output logic          RDY,
  output logic [LW-1:0] LEVEL,
  output logic          BUSY,
`ifdef UART_TX_BREAK_EN
  input  logic          BRK,
`endif
  output logic          TX
);

  localparam int NT = bit_period(BAUDS);
  localparam int TW = $clog2(NT);
  localparam int BW = 4;

  state_t         st_q, st_d;
  logic [TW-1:0]  tk_q, tk_d;
  logic [BW-1:0]  bc_q, bc_d;
  logic [W-1:0]   sh_q, sh_d;
  logic           par_q, par_d;
  logic           tx_d;
  logic           pop;
  logic           last;
  logic           nxt;
  logic           full;
  logic           empty;
  logic [W-1:0]   dout;

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .NRST  (NRST),
    .push  (OE),
    .pop   (pop),
    .din   (IN),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .level (LEVEL)
  );

  assign RDY  = !full;
  assign BUSY = (st_q != S_IDLE) || !empty;
  assign last = (tk_q == TW'(NT - 1));

  always_comb begin
    st_d  = st_q;
    tk_d  = tk_q;
    bc_d  = bc_q;
    sh_d  = sh_q;
    par_d = par_q;
    pop   = 1'b0;
    tx_d  = 1'b1;
    nxt   = 1'b0;
    if (st_q != S_IDLE) tk_d = last ? '0 : tk_q + 1'b1;
    unique case (st_q)
      S_IDLE: nxt = 1'b1;
      S_START: begin
        tx_d = 1'b0;
        if (last) st_d = S_DATA;
      end
      S_DATA: begin
        tx_d = sh_q[0];
        if (last) begin
          sh_d = sh_q >> 1;
          if (bc_q == BW'(W - 1)) begin
            bc_d = '0;
            st_d = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
          end else begin
            bc_d = bc_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        tx_d = par_q;
        if (last) st_d = S_STOP;
      end
      S_STOP: begin
        if (last) begin
          if (bc_q == BW'(WSTOP - 1)) begin
            bc_d = '0;
            nxt  = 1'b1;
          end else begin
            bc_d = bc_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BRK: begin
        tx_d = 1'b0;
        tk_d = '0;
        if (!BRK) st_d = S_MARK;
      end
      S_MARK: begin
        if (last) nxt = 1'b1;
      end
`endif
      default: st_d = S_IDLE;
    endcase
    // End of a frame (or idle): pick break, next word, or idle
    if (nxt) begin
`ifdef UART_TX_BREAK_EN
      if (BRK) begin
        st_d = S_BRK;
        tk_d = '0;
      end else
`endif
      if (!empty) begin
        pop   = 1'b1;
        st_d  = S_START;
        tk_d  = '0;
        bc_d  = '0;
        sh_d  = dout;
        par_d = (^dout) ^ (PARITY == PAR_ODD);
      end else begin
        st_d = S_IDLE;
        tk_d = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      st_q  <= S_IDLE;
      tk_q  <= '0;
      bc_q  <= '0;
      sh_q  <= '0;
      par_q <= 1'b0;
      TX    <= 1'b1;
    end else begin
      st_q  <= st_d;
      tk_q  <= tk_d;
      bc_q  <= bc_d;
      sh_q  <= sh_d;
      par_q <= par_d;
      TX    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: framing, parity, stop bits,
// FIFO overflow, reset abort and (with UART_TX_BREAK_EN) break.
`ifndef FCLK
`define FCLK 1000000
`endif

module tb_uart_tx_buf;

  localparam int BR = `FCLK / 4;

  logic       clk;
  logic       nrst [3];
  logic [7:0] din  [3];
  logic       oe   [3];
  logic       rdy  [3];
  logic [2:0] lvl  [3];
  logic       busy [3];
  logic       tx   [3];
  logic       brk0;

  int checks = 0;
  int errors = 0;
  bit exp_q [$];

  uart_tx_buf #(
    .BAUDS (BR), .W (8), .WSTOP (1), .PARITY (0), .DEPTH (4)
  ) u0 (
    .CLK   (clk),
    .NRST  (nrst[0]),
    .IN    (din[0]),
    .OE    (oe[0]),
    .RDY   (rdy[0]),
    .LEVEL (lvl[0]),
    .BUSY  (busy[0]),
`ifdef UART_TX_BREAK_EN
    .BRK   (brk0),
`endif
    .TX    (tx[0])
  );

  uart_tx_buf #(
    .BAUDS (BR), .W (8), .WSTOP (2), .PARITY (2), .DEPTH (4)
  ) u1 (
    .CLK   (clk),
    .NRST  (nrst[1]),
    .IN    (din[1]),
    .OE    (oe[1]),
    .RDY   (rdy[1]),
    .LEVEL (lvl[1]),
    .BUSY  (busy[1]),
`ifdef UART_TX_BREAK_EN
    .BRK   (1'b0),
`endif
    .TX    (tx[1])
  );

  uart_tx_buf #(
    .BAUDS (BR), .W (8), .WSTOP (1), .PARITY (1), .DEPTH (4)
  ) u2 (
    .CLK   (clk),
    .NRST  (nrst[2]),
    .IN    (din[2]),
    .OE    (oe[2]),
    .RDY   (rdy[2]),
    .LEVEL (lvl[2]),
    .BUSY  (busy[2]),
`ifdef UART_TX_BREAK_EN
    .BRK   (1'b0),
`endif
    .TX    (tx[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected TX waveform, one entry per clock (4 clocks per bit)
  task automatic build(input logic [7:0] w, input int par,
                       input int nstop);
    bit p;
    p = 1'b0;
    repeat (4) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      p ^= w[i];
      repeat (4) exp_q.push_back(w[i]);
    end
    if (par != 0) begin
      if (par == 1) p = ~p;
      repeat (4) exp_q.push_back(p);
    end
    repeat (4 * nstop) exp_q.push_back(1'b1);
  endtask

  task automatic stream(input int id, input int ncyc, input int nwr,
                        input logic [7:0] w0, input int brk_at);
    bit e;
    for (int c = 0; c < ncyc; c++) begin
      oe[id]  = (c < nwr);
      din[id] = w0 + 8'(c);
      if (c == brk_at) brk0 = 1'b1;
      tick();
      if (c < 2) e = 1'b1;
      else if (c - 2 < exp_q.size()) e = exp_q[c - 2];
      else e = 1'b1;
      chk($sformatf("tx u%0d c%0d", id, c), 32'(tx[id]), 32'(e));
      if (nwr == 6 && (c == 4 || c == 5)) begin
        chk($sformatf("lvl full c%0d", c), 32'(lvl[id]), 32'd4);
        chk($sformatf("rdy full c%0d", c), 32'(rdy[id]), 32'd0);
      end
    end
    oe[id] = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    brk0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nrst[i] = 1'b0;
      oe[i]   = 1'b0;
      din[i]  = 8'h00;
    end
    oe[0] = 1'b1;
    tick();
    tick();
    oe[0] = 1'b0;
    chk("rst tx", 32'(tx[0]), 32'd1);
    chk("rst lvl", 32'(lvl[0]), 32'd0);
    chk("rst rdy", 32'(rdy[0]), 32'd1);
    chk("rst busy", 32'(busy[0]), 32'd0);
    chk("rst tx u1", 32'(tx[1]), 32'd1);
    for (int i = 0; i < 3; i++) nrst[i] = 1'b1;
    tick();

    // Single 8N1 frame of 0xA5
    build(8'hA5, 0, 1);
    stream(0, 44, 1, 8'hA5, -1);
    chk("busy after A5", 32'(busy[0]), 32'd0);

    // Even parity, two stop bits, 0x07
    build(8'h07, 2, 2);
    stream(1, 52, 1, 8'h07, -1);

    // Odd parity, 0x07
    build(8'h07, 1, 1);
    stream(2, 46, 1, 8'h07, -1);

    // Two queued words with two stop bits
    build(8'h30, 2, 2);
    build(8'h31, 2, 2);
    stream(1, 102, 2, 8'h30, -1);
    chk("busy u1 done", 32'(busy[1]), 32'd0);

    // Six writes into depth 4: five accepted, sixth dropped
    for (int i = 1; i <= 5; i++) build(8'(i), 0, 1);
    stream(0, 206, 6, 8'h01, -1);
    chk("busy ovf done", 32'(busy[0]), 32'd0);
    chk("lvl ovf done", 32'(lvl[0]), 32'd0);

    // Reset in the middle of DATA with a word still queued
    for (int c = 0; c < 12; c++) begin
      oe[0]  = (c < 2);
      din[0] = 8'h00;
      tick();
    end
    chk("pre-rst tx", 32'(tx[0]), 32'd0);
    chk("pre-rst lvl", 32'(lvl[0]), 32'd1);
    nrst[0] = 1'b0;
    oe[0]   = 1'b1;
    tick();
    nrst[0] = 1'b1;
    oe[0]   = 1'b0;
    chk("abort tx", 32'(tx[0]), 32'd1);
    chk("abort lvl", 32'(lvl[0]), 32'd0);
    chk("abort rdy", 32'(rdy[0]), 32'd1);
    chk("abort busy", 32'(busy[0]), 32'd0);
    for (int c = 0; c < 50; c++) begin
      tick();
      chk($sformatf("post-rst tx c%0d", c), 32'(tx[0]), 32'd1);
    end
    chk("post-rst busy", 32'(busy[0]), 32'd0);

`ifdef UART_TX_BREAK_EN
    // Break raised mid-frame, released later
    build(8'h55, 0, 1);
    stream(0, 42, 1, 8'h55, 10);
    oe[0]  = 1'b1;
    din[0] = 8'h5A;
    tick();
    oe[0] = 1'b0;
    chk("brk tx", 32'(tx[0]), 32'd0);
    chk("brk lvl", 32'(lvl[0]), 32'd1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("brk hold tx c%0d", c), 32'(tx[0]), 32'd0);
      chk($sformatf("brk busy c%0d", c), 32'(busy[0]), 32'd1);
      chk($sformatf("brk lvl c%0d", c), 32'(lvl[0]), 32'd1);
    end
    brk0 = 1'b0;
    tick();
    chk("brk fall tx", 32'(tx[0]), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("mark tx c%0d", c), 32'(tx[0]), 32'd1);
    end
    tick();
    chk("brk next start", 32'(tx[0]), 32'd0);
    repeat (45) tick();
    chk("brk done busy", 32'(busy[0]), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter BAUDS, default 115200, meaning line rate; bit period NT = `FCLK/BAUDS clocks, NT >= 2.
REQ-002 SHALL have parameter W, default 8, meaning data bits per frame, range 5..9.
REQ-003 SHALL have parameter WSTOP, default 1, meaning stop bits, 1 or 2.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter DEPTH, default 16, meaning FIFO words, power of two >= 2.
REQ-006 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port NRST  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port IN  input  W  word to transmit.
REQ-009 SHALL have port OE  input  1  write strobe; word accepted on an edge where OE && RDY.
REQ-010 SHALL have port RDY  output  1  FIFO not full.
REQ-011 SHALL have port LEVEL  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-012 SHALL have port BUSY  output  1  frame in progress, or FIFO non-empty.
REQ-013 SHALL have port TX  output  1  serial line, idle high, registered.

Function
REQ-014 SHALL run FSM IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE, or STOP -> START if FIFO non-empty.
REQ-015 SHALL hold each bit on TX for exactly NT clocks; each stop bit also lasts NT clocks.
REQ-016 SHALL send start bit 0, data LSB first, parity bit, then WSTOP stop bits at 1.
REQ-017 SHALL compute parity as XOR of the W data bits; even = XOR, odd = ~XOR.
REQ-018 SHALL pop the FIFO in IDLE when it is non-empty; OE accepted at edge k into an empty idle block drives TX low from edge k+2.
REQ-019 SHALL start frames back-to-back with no idle gap while the FIFO is non-empty.
REQ-020 SHALL ignore OE while RDY is low; the word is dropped and state is unchanged.
REQ-021 SHALL derive RDY from registered LEVEL; a pop in the same edge does not admit a write when full.
REQ-022 SHALL update LEVEL by +1 on write only, -1 on pop only, and leave it unchanged on a simultaneous write and pop.
REQ-023 SHALL wrap read and write pointers modulo DEPTH.

Reset
REQ-024 SHALL, on an edge with NRST low, set TX=1, LEVEL=0, RDY=1, BUSY=0, FSM=IDLE, and clear the bit counter and tick counter.
REQ-025 SHALL abort a frame in progress on reset mid-frame; TX is 1 after that edge and the frame is not resumed.
REQ-026 SHALL ignore OE on edges with NRST low.

Configuration
REQ-027 SHALL, with macro UART_TX_BREAK_EN defined, add port BRK input 1; with BRK high, the current frame completes, TX is then held 0 and FIFO pops pause with BUSY=1; after BRK falls, TX=1 for one NT before the next frame.
REQ-028 SHALL, without UART_TX_BREAK_EN, have no BRK port and no break logic.

Structure
REQ-029 SHALL place the FSM state enum, the parity-mode constants and the bit-period function in shared package uart_pkg.
REQ-030 SHALL implement the FIFO as sub-module sync_fifo (parameters WIDTH, DEPTH; ports CLK, NRST, push/pop, full/empty, level).

Verification
Bench: `FCLK=1000000, BAUDS=250000 -> NT=4.
REQ-031 SHALL cover: W=8, PARITY=0, WSTOP=1, write 0xA5 idle at edge k -> TX low edges k+2..k+5, then 1,0,1,0,0,1,0,1 at 4 clocks each, then stop high 4 clocks; frame 40 clocks.
REQ-032 SHALL cover: PARITY=2, write 0x07 -> parity bit 1; PARITY=1 -> parity bit 0.
REQ-033 SHALL cover: DEPTH=4, 6 consecutive OE while a frame runs -> 5 accepted (1 popped plus 4 buffered), RDY low, 6th dropped, 5 frames sent back-to-back with no gap.
REQ-034 SHALL cover: NRST low mid-DATA -> TX=1 next edge, LEVEL=0, no further frames.
REQ-035 SHALL cover: WSTOP=2, two queued words -> 8 stop clocks between frames.
REQ-036 SHALL cover: UART_TX_BREAK_EN, BRK high mid-frame -> frame completes, TX=0 until BRK falls, then 4 clocks high before the next frame.
